// File: rtl/mig_fetch_arbiter.sv
// Shared instruction-fetch arbiter for the Mig multi-core CPU: round-robin among cores,
// burst-limited debug priority, and routing of the 1-cycle-latency SimRAM read data.
module mig_fetch_arbiter #(
    parameter int NR_CORES      = 2,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DBG_MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NR_CORES-1:0]            core_req,
    input  logic [NR_CORES*ADDR_WIDTH-1:0] core_addr,
    output logic [NR_CORES-1:0]            core_gnt,
    output logic [NR_CORES-1:0]            core_rsp_valid,
    input  logic                           dbg_req,
    input  logic [ADDR_WIDTH-1:0]          dbg_addr,
    output logic                           dbg_gnt,
    output logic                           dbg_rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           ram_rd_en,
    output logic [ADDR_WIDTH-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ram_rd_data
);

    localparam int PTR_W = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
    localparam int CNT_W = $clog2(DBG_MAX_BURST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NR_CORES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DBG_MAX_BURST);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;
    logic              win_found;
    logic [CNT_W-1:0]  dbg_cnt;
    logic [NR_CORES:0] rsp_sel;
    logic              dbg_win;
    logic              core_win;

    // First requesting core at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NR_CORES; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NR_CORES);
            if (!win_found && core_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Debug only loses once its burst is spent and a core is actually waiting.
    assign dbg_win  = dbg_req && ((dbg_cnt < CNT_MAX) || !(|core_req));
    assign dbg_gnt  = !rst && dbg_win;
    assign core_win = !rst && !dbg_win && win_found;

    always_comb begin
        core_gnt = '0;
        if (core_win) begin
            core_gnt[win_idx] = 1'b1;
        end
    end

    assign ram_rd_en = dbg_gnt || core_win;

    always_comb begin
        ram_rd_addr = '0;
        if (dbg_gnt) begin
            ram_rd_addr = dbg_addr;
        end else if (core_win) begin
            ram_rd_addr = core_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            dbg_cnt <= '0;
            rsp_sel <= '0;
        end else begin
            rsp_sel <= {dbg_gnt, core_gnt};
            if (dbg_gnt) begin
                dbg_cnt <= (dbg_cnt == CNT_MAX) ? dbg_cnt : dbg_cnt + 1'b1;
            end else begin
                dbg_cnt <= '0;
            end
            if (core_win) begin
                rr_ptr <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

    assign core_rsp_valid = rsp_sel[NR_CORES-1:0];
    assign dbg_rsp_valid  = rsp_sel[NR_CORES];
    assign rsp_data       = ram_rd_data;

endmodule

// File: tb/tb_mig_fetch_arbiter.sv
// Directed bench for mig_fetch_arbiter (4 cores, debug burst 4) with a behavioural
// 1-cycle-latency RAM; expected grants are hand-written per cycle.
module tb_mig_fetch_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DMB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    core_req;
    logic [NC*AW-1:0] core_addr;
    logic [NC-1:0]    core_gnt;
    logic [NC-1:0]    core_rsp_valid;
    logic             dbg_req;
    logic [AW-1:0]    dbg_addr;
    logic             dbg_gnt;
    logic             dbg_rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_rd_addr;
    logic [DW-1:0]    ram_rd_data = '0;

    logic [DW-1:0]    mem [256];
    logic [NC-1:0]    prev_gnt;
    logic             prev_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mig_fetch_arbiter #(
        .NR_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_MAX_BURST(DMB)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rsp_valid(core_rsp_valid),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rsp_valid(dbg_rsp_valid), .rsp_data(rsp_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    function automatic logic [AW-1:0] coreAddrOf(input logic [NC-1:0] onehot);
        logic [AW-1:0] a;
        a = '0;
        for (int i = 0; i < NC; i++) if (onehot[i]) a = 8'h20 + AW'(i);
        return a;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NC-1:0] creq, input logic dreq);
        @(negedge clk);
        rst      = r;
        core_req = creq;
        dbg_req  = dreq;
        #1;
    endtask

    // One cycle: drive, then check this cycle's grants and last cycle's response.
    task automatic stepCycle(input string tag, input logic r, input logic [NC-1:0] creq,
                             input logic dreq, input logic [NC-1:0] egnt, input logic edbg);
        logic [AW-1:0] eaddr;
        applyStimulus(r, creq, dreq);
        eaddr = edbg ? 8'h10 : coreAddrOf(egnt);
        checkOutput({tag, ".core_gnt"}, 64'(core_gnt), 64'(egnt));
        checkOutput({tag, ".dbg_gnt"}, 64'(dbg_gnt), 64'(edbg));
        checkOutput({tag, ".ram_rd_en"}, 64'(ram_rd_en), 64'((|egnt) | edbg));
        checkOutput({tag, ".ram_rd_addr"}, 64'(ram_rd_addr), 64'(eaddr));
        checkOutput({tag, ".core_rsp_valid"}, 64'(core_rsp_valid), 64'(prev_gnt));
        checkOutput({tag, ".dbg_rsp_valid"}, 64'(dbg_rsp_valid), 64'(prev_dbg));
        if (prev_dbg)
            checkOutput({tag, ".rsp_data"}, 64'(rsp_data), 64'(memWord(8'h10)));
        else if (|prev_gnt)
            checkOutput({tag, ".rsp_data"}, 64'(rsp_data), 64'(memWord(coreAddrOf(prev_gnt))));
        prev_gnt = r ? '0 : egnt;
        prev_dbg = r ? 1'b0 : edbg;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = memWord(AW'(a));
        core_addr = {8'h23, 8'h22, 8'h21, 8'h20};
        dbg_addr  = 8'h10;
        rst       = 1'b1;
        core_req  = 4'b1111;
        dbg_req   = 1'b1;
        prev_gnt  = '0;
        prev_dbg  = 1'b0;

        for (int i = 0; i < 2; i++) stepCycle($sformatf("reset%0d", i), 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);

        for (int i = 0; i < 8; i++)
            stepCycle($sformatf("rr%0d", i), 1'b0, 4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b0);
        stepCycle("rr_drain", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        stepCycle("sparse_c2", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
        stepCycle("sparse_c3", 1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0);
        stepCycle("sparse_c0", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
        stepCycle("sparse_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                stepCycle($sformatf("burst%0d", i), 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0);
            else
                stepCycle($sformatf("burst%0d", i), 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b1);
        end
        stepCycle("burst_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 10; i++)
            stepCycle($sformatf("dbg_alone%0d", i), 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        stepCycle("dbg_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // rr_ptr is 2 here; the core-2 grant moves it to 3 before reset hits.
        stepCycle("mid_c2", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
        stepCycle("mid_rst", 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0);
        stepCycle("mid_after", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
        stepCycle("mid_drain", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
